// File: rtl/byte_ram_store_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : byte_ram_store_serializer_if
//  Description : Store-request handshake plus byte-wide RAM write port
//                bundled for the byte RAM store serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface byte_ram_store_serializer_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              done;
  logic              err;

  // Requester side (MEM stage / preload logic); it also observes the RAM strobes.
  modport master (
    output req_valid, req_addr, req_data, req_size,
    input  req_ready, ram_we, ram_addr, ram_din, done, err
  );

  // Serializer side.
  modport slave (
    input  req_valid, req_addr, req_data, req_size,
    output req_ready, ram_we, ram_addr, ram_din, done, err
  );
endinterface
`default_nettype wire

// File: rtl/byte_ram_store_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_ram_store_serializer
//  Description : Accepts one byte/halfword/word store and replays it as N
//                consecutive single-byte writes to a byte-wide RAM port.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_ram_store_serializer #(
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  byte_ram_store_serializer_if.slave   bus_io
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [2:0]        n_q;       // bytes in the accepted store (1/2/4)
  logic [1:0]        k_q;       // index of the byte currently on the RAM port
  logic              req_ready_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_din_q;
  logic              done_q;
  logic              err_q;

  logic [2:0]        acc_n_d;
  logic              acc_bad_d;
  logic [1:0]        k_d;
  logic [7:0]        first_byte_d;
  logic [7:0]        next_byte_d;
  logic              last_d;

  // Pick byte k of an n-byte store; big-endian sends the most significant byte first.
  function automatic logic [7:0] sel_byte(input logic [31:0] d,
                                          input logic [2:0]  n,
                                          input logic [1:0]  k);
    logic [2:0] t;
    logic [1:0] idx;
    t   = n - 3'd1 - {1'b0, k};
    idx = (BIG_ENDIAN) ? t[1:0] : k;
    return d[{idx, 3'b000} +: 8];
  endfunction

  // Decode the incoming request and precompute the next byte to drive.
  always_comb begin
    acc_n_d   = 3'd0;
    acc_bad_d = 1'b0;
    case (bus_io.req_size)
      2'b00: acc_n_d = 3'd1;
      2'b01: begin
        acc_n_d   = 3'd2;
        acc_bad_d = bus_io.req_addr[0];
      end
      2'b10: begin
        acc_n_d   = 3'd4;
        acc_bad_d = (bus_io.req_addr[1:0] != 2'b00);
      end
      default: acc_bad_d = 1'b1;
    endcase
    k_d          = k_q + 2'd1;
    last_d       = ({1'b0, k_q} == (n_q - 3'd1));
    first_byte_d = sel_byte(bus_io.req_data, acc_n_d, 2'd0);
    next_byte_d  = sel_byte(data_q, n_q, k_d);
  end

  // Control FSM with registered handshake and RAM-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      n_q         <= '0;
      k_q         <= '0;
      req_ready_q <= 1'b1;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (bus_io.req_valid && req_ready_q) begin
            addr_q      <= bus_io.req_addr;
            data_q      <= bus_io.req_data;
            n_q         <= acc_n_d;
            k_q         <= 2'd0;
            req_ready_q <= 1'b0;
            if (acc_bad_d) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else begin
              // First byte goes out in the cycle right after acceptance.
              state_q    <= S_WRITE;
              ram_we_q   <= 1'b1;
              ram_addr_q <= bus_io.req_addr;
              ram_din_q  <= first_byte_d;
            end
          end
        end
        S_WRITE: begin
          if (last_d) begin
            state_q  <= S_DONE;
            ram_we_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            k_q        <= k_d;
            ram_addr_q <= addr_q + ADDR_W'(k_d);
            ram_din_q  <= next_byte_d;
          end
        end
        S_DONE: begin
          done_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        S_ERR: begin
          err_q       <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          ram_we_q    <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus_io.req_ready = req_ready_q;
  assign bus_io.ram_we    = ram_we_q;
  assign bus_io.ram_addr  = ram_addr_q;
  assign bus_io.ram_din   = ram_din_q;
  assign bus_io.done      = done_q;
  assign bus_io.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_ram_store_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_ram_store_serializer
//  Description : Directed bench for the byte RAM store serializer, with a
//                big-endian and a little-endian instance each feeding a RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_ram_store_serializer;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  logic [7:0] mem_be [256];
  logic [7:0] mem_le [256];

  byte_ram_store_serializer_if #(.ADDR_W(8)) be_if ();
  byte_ram_store_serializer_if #(.ADDR_W(8)) le_if ();

  byte_ram_store_serializer #(.ADDR_W(8), .BIG_ENDIAN(1'b1)) u_be (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (be_if.slave)
  );

  byte_ram_store_serializer #(.ADDR_W(8), .BIG_ENDIAN(1'b0)) u_le (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (le_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAMs written by the two serializers.
  always @(posedge clk) begin
    if (be_if.ram_we) mem_be[be_if.ram_addr] <= be_if.ram_din;
    if (le_if.ram_we) mem_le[le_if.ram_addr] <= le_if.ram_din;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [7:0] a, input logic [7:0] d);
    chk({tag, "_we"},   32'(be_if.ram_we),   32'd1);
    chk({tag, "_addr"}, 32'(be_if.ram_addr), 32'(a));
    chk({tag, "_din"},  32'(be_if.ram_din),  32'(d));
  endtask

  task automatic chk_le_wr(input string tag, input logic [7:0] a, input logic [7:0] d);
    chk({tag, "_we"},   32'(le_if.ram_we),   32'd1);
    chk({tag, "_addr"}, 32'(le_if.ram_addr), 32'(a));
    chk({tag, "_din"},  32'(le_if.ram_din),  32'(d));
  endtask

  task automatic be_req(input logic [7:0] a, input logic [31:0] d, input logic [1:0] s);
    be_if.req_valid = 1'b1;
    be_if.req_addr  = a;
    be_if.req_data  = d;
    be_if.req_size  = s;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    for (int i = 0; i < 256; i++) begin
      mem_be[i] = 8'h00;
      mem_le[i] = 8'h00;
    end
    be_if.req_valid = 1'b0;
    be_if.req_addr  = '0;
    be_if.req_data  = '0;
    be_if.req_size  = '0;
    le_if.req_valid = 1'b0;
    le_if.req_addr  = '0;
    le_if.req_data  = '0;
    le_if.req_size  = '0;
    rst_n = 1'b0;
    step();
    step();

    // Reset values
    chk("rst_ready", 32'(be_if.req_ready), 32'd1);
    chk("rst_we",    32'(be_if.ram_we),    32'd0);
    chk("rst_addr",  32'(be_if.ram_addr),  32'd0);
    chk("rst_din",   32'(be_if.ram_din),   32'd0);
    chk("rst_done",  32'(be_if.done),      32'd0);
    chk("rst_err",   32'(be_if.err),       32'd0);
    rst_n = 1'b1;
    step();

    // Word store, big-endian
    be_req(8'h00, 32'hE3A01005, 2'b10);
    step();
    chk_wr("w0_c1", 8'h00, 8'hE3);
    chk("w0_c1_ready", 32'(be_if.req_ready), 32'd0);
    be_if.req_valid = 1'b0;
    step(); chk_wr("w0_c2", 8'h01, 8'hA0);
    step(); chk_wr("w0_c3", 8'h02, 8'h10);
    step(); chk_wr("w0_c4", 8'h03, 8'h05);
    step();
    chk("w0_c5_done",  32'(be_if.done),      32'd1);
    chk("w0_c5_we",    32'(be_if.ram_we),    32'd0);
    chk("w0_c5_ready", 32'(be_if.req_ready), 32'd0);
    step();
    chk("w0_c6_ready", 32'(be_if.req_ready), 32'd1);
    chk("w0_c6_done",  32'(be_if.done),      32'd0);
    chk("w0_readback", {mem_be[0], mem_be[1], mem_be[2], mem_be[3]}, 32'hE3A01005);

    // Halfword store
    be_req(8'h22, 32'h0000BEEF, 2'b01);
    step(); chk_wr("h_c1", 8'h22, 8'hBE);
    be_if.req_valid = 1'b0;
    step(); chk_wr("h_c2", 8'h23, 8'hEF);
    step(); chk("h_c3_done", 32'(be_if.done), 32'd1);
    step(); chk("h_c4_ready", 32'(be_if.req_ready), 32'd1);

    // Byte store
    be_req(8'h41, 32'h12345677, 2'b00);
    step(); chk_wr("b_c1", 8'h41, 8'h77);
    be_if.req_valid = 1'b0;
    step();
    chk("b_c2_done", 32'(be_if.done),   32'd1);
    chk("b_c2_we",   32'(be_if.ram_we), 32'd0);
    step(); chk("b_c3_ready", 32'(be_if.req_ready), 32'd1);
    chk("b_mem41", 32'(mem_be[8'h41]), 32'h77);
    chk("b_mem42", 32'(mem_be[8'h42]), 32'h00);

    // Misaligned word
    be_req(8'h06, 32'h11111111, 2'b10);
    step();
    chk("mis_c1_err",   32'(be_if.err),       32'd1);
    chk("mis_c1_we",    32'(be_if.ram_we),    32'd0);
    chk("mis_c1_done",  32'(be_if.done),      32'd0);
    chk("mis_c1_ready", 32'(be_if.req_ready), 32'd0);
    be_if.req_valid = 1'b0;
    step();
    chk("mis_c2_ready", 32'(be_if.req_ready), 32'd1);
    chk("mis_c2_err",   32'(be_if.err),       32'd0);
    chk("mis_c2_we",    32'(be_if.ram_we),    32'd0);
    chk("mis_mem06",    32'(mem_be[8'h06]),   32'h00);

    // Illegal size
    be_req(8'h10, 32'h22222222, 2'b11);
    step();
    chk("ill_c1_err", 32'(be_if.err),    32'd1);
    chk("ill_c1_we",  32'(be_if.ram_we), 32'd0);
    be_if.req_valid = 1'b0;
    step();
    chk("ill_c2_ready", 32'(be_if.req_ready), 32'd1);
    chk("ill_mem10",    32'(mem_be[8'h10]),   32'h00);

    // Misaligned halfword
    be_req(8'h23, 32'h0000AAAA, 2'b01);
    step();
    chk("mish_c1_err", 32'(be_if.err),    32'd1);
    chk("mish_c1_we",  32'(be_if.ram_we), 32'd0);
    be_if.req_valid = 1'b0;
    step();

    // Back-to-back words with valid held; inputs change mid-store
    be_req(8'h04, 32'hCAFEF00D, 2'b10);
    step(); chk_wr("bb_c1", 8'h04, 8'hCA);
    be_req(8'hFC, 32'h01020304, 2'b10);
    step(); chk_wr("bb_c2", 8'h05, 8'hFE);
    step(); chk_wr("bb_c3", 8'h06, 8'hF0);
    step(); chk_wr("bb_c4", 8'h07, 8'h0D);
    step();
    chk("bb_c5_done",  32'(be_if.done),      32'd1);
    chk("bb_c5_ready", 32'(be_if.req_ready), 32'd0);
    step();
    chk("bb_c6_ready", 32'(be_if.req_ready), 32'd1);
    chk("bb_c6_we",    32'(be_if.ram_we),    32'd0);
    step(); chk_wr("bb_c7", 8'hFC, 8'h01);
    be_if.req_valid = 1'b0;
    step(); chk_wr("bb_c8",  8'hFD, 8'h02);
    step(); chk_wr("bb_c9",  8'hFE, 8'h03);
    step(); chk_wr("bb_c10", 8'hFF, 8'h04);
    step(); chk("bb_c11_done",  32'(be_if.done),      32'd1);
    step(); chk("bb_c12_ready", 32'(be_if.req_ready), 32'd1);
    chk("bb_mem04", {mem_be[4], mem_be[5], mem_be[6], mem_be[7]}, 32'hCAFEF00D);
    chk("bb_memFC", {mem_be[252], mem_be[253], mem_be[254], mem_be[255]}, 32'h01020304);
    chk("bb_nowrap", 32'(mem_be[0]), 32'hE3);

    // Reset in the middle of a word store
    be_req(8'h08, 32'h11223344, 2'b10);
    step(); chk_wr("rm_c1", 8'h08, 8'h11);
    be_if.req_valid = 1'b0;
    step(); chk_wr("rm_c2", 8'h09, 8'h22);
    step();
    rst_n = 1'b0;
    #1;
    chk("rm_we",    32'(be_if.ram_we),    32'd0);
    chk("rm_ready", 32'(be_if.req_ready), 32'd1);
    chk("rm_done",  32'(be_if.done),      32'd0);
    step();
    chk("rm_done2", 32'(be_if.done), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rm_done3", 32'(be_if.done),   32'd0);
    chk("rm_we3",   32'(be_if.ram_we), 32'd0);
    step();
    chk("rm_mem", {mem_be[8], mem_be[9], mem_be[10], mem_be[11]}, 32'h11220000);

    // Little-endian instance
    le_if.req_valid = 1'b1;
    le_if.req_addr  = 8'h10;
    le_if.req_data  = 32'hE3A01005;
    le_if.req_size  = 2'b10;
    step(); chk_le_wr("le_c1", 8'h10, 8'h05);
    le_if.req_valid = 1'b0;
    step(); chk_le_wr("le_c2", 8'h11, 8'h10);
    step(); chk_le_wr("le_c3", 8'h12, 8'hA0);
    step(); chk_le_wr("le_c4", 8'h13, 8'hE3);
    step();
    chk("le_c5_done", 32'(le_if.done),   32'd1);
    chk("le_c5_we",   32'(le_if.ram_we), 32'd0);
    step();
    chk("le_c6_ready", 32'(le_if.req_ready), 32'd1);
    chk("le_mem", {mem_le[8'h13], mem_le[8'h12], mem_le[8'h11], mem_le[8'h10]}, 32'hE3A01005);

    // Little-endian halfword
    le_if.req_valid = 1'b1;
    le_if.req_addr  = 8'h22;
    le_if.req_data  = 32'h0000BEEF;
    le_if.req_size  = 2'b01;
    step(); chk_le_wr("leh_c1", 8'h22, 8'hEF);
    le_if.req_valid = 1'b0;
    step(); chk_le_wr("leh_c2", 8'h23, 8'hBE);
    step(); chk("leh_c3_done", 32'(le_if.done), 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/byte_ram_store_serializer.md
Name: byte_ram_store_serializer

Overview:
- Write-side counterpart of the 256x8 byte-addressed instruction/data RAM read path.
- Accepts one 32-bit store request (byte, halfword or word) over a valid/ready handshake.
- Serializes the request into consecutive single-byte writes on the RAM's byte-wide write port, in big-endian order.
- Sits between the MEM pipeline stage (or the bench preload logic) and the byte RAM array.

Parameters:
- ADDR_W, 8, RAM byte-address width (depth = 2^ADDR_W bytes).
- BIG_ENDIAN, 1: 1 = most-significant byte at the lowest address; 0 = little-endian.

Ports:
- clk        input   1       rising-edge clock.
- rst_n      input   1       asynchronous active-low reset.
- req_valid  input   1       store request present.
- req_ready  output  1       serializer idle; request accepted when req_valid & req_ready.
- req_addr   input   ADDR_W  byte address of the store.
- req_data   input   32      store data; byte and halfword use the low bits.
- req_size   input   2       00 byte, 01 halfword, 10 word, 11 illegal.
- ram_we     output  1       byte write strobe to the RAM.
- ram_addr   output  ADDR_W  byte address of the current write.
- ram_din    output  8       byte being written.
- done       output  1       one-cycle pulse: store completed.
- err        output  1       one-cycle pulse: request rejected, no write.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE. req_ready=1; ram_we=0, ram_addr=0, ram_din=0, done=0, err=0.
  - Byte counter and request registers are cleared.
- States: IDLE, WRITE, DONE, ERR.
- IDLE:
  - req_ready=1.
  - On accept, register addr, data and size, and compute N (1/2/4 bytes).
  - Aligned legal request goes to WRITE with counter k=0.
  - Misalignment (half with addr[0]=1, word with addr[1:0]!=0) or size=11 goes to ERR.
- WRITE:
  - req_ready=0, ram_we=1, ram_addr = base+k, ram_din = byte k.
  - k increments each cycle. After k=N-1 go to DONE.
  - Exactly N consecutive write cycles, no gaps.
- Byte ordering with BIG_ENDIAN=1:
  - Word: k=0 gets data[31:24], k=1 [23:16], k=2 [15:8], k=3 [7:0].
  - Half: k=0 gets data[15:8], k=1 [7:0].
  - Byte: data[7:0].
- Byte ordering with BIG_ENDIAN=0: reverse order, lowest-significance byte first.
- DONE: done=1 for one cycle, ram_we=0, req_ready=0. Next state IDLE.
- ERR: err=1 for one cycle, ram_we=0, no write issued. Next state IDLE.
- Latency:
  - Accept at edge 0; writes occur on cycles 1..N; done on cycle N+1; req_ready=1 again on cycle N+2.
  - Throughput is one store per N+2 cycles.
- Addressing:
  - ram_addr = base+k computed modulo 2^ADDR_W.
  - Aligned requests never wrap within a store; the top word (0xFC) writes 0xFC..0xFF.
- Request inputs are ignored while req_ready=0. Registered copies alone drive the RAM, so input changes mid-store have no effect.
- ram_addr and ram_din hold their last values when ram_we=0. They are don't-care for the RAM.
- Reset mid-store: the remaining bytes are abandoned, done is not issued, and outputs take reset values immediately. Bytes already written remain in the RAM.
- done and err are never asserted together. ram_we is never high in DONE, ERR or IDLE.

Test Plan:
- Word store, addr=0x00, data=0xE3A01005 -> writes (0x00,E3)(0x01,A0)(0x02,10)(0x03,05) on cycles 1–4, done on cycle 5. Reading the word back through the RAM read port at 0x00 returns 0xE3A01005.
- Halfword store, addr=0x22, data=0x0000BEEF -> writes (0x22,BE)(0x23,EF), done on cycle 3. Byte store, addr=0x41, data=0x12345677 -> single write (0x41,77), done on cycle 2.
- Misaligned word at addr=0x06, and size=11 at addr=0x10 -> err pulse on cycle 1, ram_we stays 0, req_ready=1 on cycle 2. RAM contents unchanged.
- Back-to-back: req_valid held high with two word stores to 0x04 and 0xFC -> second accepted only when req_ready returns (cycle 6). Writes to 0xFC..0xFF with no wrap; total 12 cycles.
- Reset mid-store: assert rst_n=0 after 2 bytes of a word store to 0x08 -> ram_we=0 and req_ready=1 immediately, no done pulse. Bytes 0x08/0x09 are written and 0x0A/0x0B are untouched.
- BIG_ENDIAN=0 instance, word 0xE3A01005 at 0x10 -> writes (0x10,05)(0x11,10)(0x12,A0)(0x13,E3).
